// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between the LC-3 fetch/data requesters, the memory arbiter and the
// external single-port memory.
interface lc3_mem_arbiter_if;
  logic        f_req;
  logic [15:0] f_addr;
  logic [15:0] f_data;
  logic        f_valid;
  logic        f_stall;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_stall;
  logic        rd;
  logic        we;
  logic [15:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        complete;
  logic        err;

  // Arbiter side.
  modport slave (
    input  f_req, f_addr, m_req, m_we, m_addr, m_wdata, dout, complete,
    output f_data, f_valid, f_stall, m_data, m_valid, m_stall, rd, we, addr, din, err
  );

  // Requesters and memory side.
  modport master (
    output f_req, f_addr, m_req, m_we, m_addr, m_wdata, dout, complete,
    input  f_data, f_valid, f_stall, m_data, m_valid, m_stall, rd, we, addr, din, err
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction
// at a time, with fetch anti-starvation and a bounded wait for memory completion.
module lc3_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic              clock,
  input logic              reset,
  lc3_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = data requester owns the port
  logic        rd_q, rd_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [15:0] f_data_q, f_data_d;
  logic [15:0] m_data_q, m_data_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  wait_q, wait_d;

  logic starving, grant_m, grant_f, grant, timeout_hit;
  logic f_valid, m_valid;

  always_comb begin
    starving    = bus.f_req && (starve_q == 4'(STARVE_LIMIT));
    grant_m     = bus.m_req && !starving;
    grant_f     = bus.f_req && !grant_m;
    grant       = grant_m || grant_f;
    timeout_hit = (wait_q == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StBusy;
      StBusy:  if (bus.complete || timeout_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d  = owner_q;
    rd_d     = rd_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    din_d    = din_q;
    f_data_d = f_data_q;
    m_data_d = m_data_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d = grant_m;
          rd_d    = grant_f || (grant_m && !bus.m_we);
          we_d    = grant_m && bus.m_we;
          addr_d  = grant_m ? bus.m_addr : bus.f_addr;
          din_d   = grant_m ? bus.m_wdata : 16'h0000;
          err_d   = 1'b0;
          wait_d  = 8'd0;
        end
        // Only data grants made while fetch is waiting count toward starvation.
        if (!bus.f_req || grant_f) begin
          starve_d = 4'd0;
        end else if (grant_m && !starving) begin
          starve_d = starve_q + 4'd1;
        end
      end
      StBusy: begin
        if (bus.complete) begin
          rd_d = 1'b0;
          we_d = 1'b0;
          if (!we_q) begin
            if (owner_q) m_data_d = bus.dout;
            else         f_data_d = bus.dout;
          end
        end else if (timeout_hit) begin
          rd_d  = 1'b0;
          we_d  = 1'b0;
          err_d = 1'b1;
          if (owner_q) m_data_d = 16'h0000;
          else         f_data_d = 16'h0000;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDone:  err_d = 1'b0;
      default: err_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q  <= 1'b0;
      rd_q     <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= 16'h0000;
      din_q    <= 16'h0000;
      f_data_q <= 16'h0000;
      m_data_q <= 16'h0000;
      starve_q <= 4'd0;
      wait_q   <= 8'd0;
    end else begin
      owner_q  <= owner_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      f_data_q <= f_data_d;
      m_data_q <= m_data_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    f_valid     = (state_q == StDone) && !owner_q;
    m_valid     = (state_q == StDone) && owner_q;
    bus.f_valid = f_valid;
    bus.m_valid = m_valid;
    bus.f_stall = bus.f_req && !f_valid;
    bus.m_stall = bus.m_req && !m_valid;
    bus.f_data  = f_data_q;
    bus.m_data  = m_data_q;
    bus.rd      = rd_q;
    bus.we      = we_q;
    bus.addr    = addr_q;
    bus.din     = din_q;
    bus.err     = err_q;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Single-port memory arbiter and sequencer for the pipelined LC-3 core. It shares the one external memory port (`rd`/`we`/`addr`/`din`/`dout`/`complete`) between the instruction-fetch requester and the memory-access (load/store) requester. It issues one transaction at a time, returns read data with a one-cycle valid pulse, and aborts transactions that exceed a bounded wait. It also produces the per-requester stall signals that freeze the pipeline registers.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits before fetch is forced (1..15).
- `TIMEOUT`, 255: maximum cycles in BUSY without `complete` before abort (1..255).

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch read request, level, held until `f_valid`.
- `f_addr` in 16: fetch address, stable while `f_req`.
- `f_data` out 16: fetched word, valid when `f_valid`.
- `f_valid` out 1: one-cycle completion pulse for fetch.
- `f_stall` out 1: `f_req & ~f_valid`, combinational.
- `m_req` in 1: data request, level, held until `m_valid`.
- `m_we` in 1: 1 = store, 0 = load; stable while `m_req`.
- `m_addr` in 16: data address.
- `m_wdata` in 16: store data.
- `m_data` out 16: load data, valid when `m_valid`.
- `m_valid` out 1: one-cycle completion pulse for data.
- `m_stall` out 1: `m_req & ~m_valid`, combinational.
- `rd` out 1: memory read strobe, registered.
- `we` out 1: memory write strobe, registered.
- `addr` out 16: memory address, registered.
- `din` out 16: memory write data, registered.
- `dout` in 16: memory read data, sampled when `complete`.
- `complete` in 1: memory done, sampled each cycle in BUSY.
- `err` out 1: one-cycle pulse when a transaction times out.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE.** The arbiter evaluates requests.
  - If `m_req` and not starving, grant data.
  - Else if `f_req`, grant fetch.
  - Else if `m_req`, grant data.
  - Starving means `f_req` is high and `starve_cnt == STARVE_LIMIT`.
  - On grant, at the next edge: latch the owner, load `addr`/`din`, assert `rd` (load or fetch) or `we` (store), clear the wait counter, and go to BUSY.
- **starve_cnt.** Increments on each data grant made while `f_req` is high. Clears on any fetch grant. Clears in IDLE when `f_req` is low. Saturates at `STARVE_LIMIT`.
- **BUSY.** `rd`/`we`/`addr`/`din` are held constant.
  - If `complete` is high: capture `dout` into the owner's data register (loads and fetches only; `m_data` is unchanged on a store), drop `rd`/`we`, and go to DONE.
  - Else if the wait counter equals `TIMEOUT-1`: drop strobes, load the owner's data register with 16'h0000, set the error flag, and go to DONE.
  - Else increment the wait counter.
- **DONE.** Lasts one cycle.
  - The owner's valid is high; `err` is high if the transaction aborted.
  - Requests are ignored, so the requester drops or changes `req` in this cycle.
  - Next state is IDLE.
- Only one of `rd`/`we` is ever high. Both are low outside BUSY.

## Timing
- Reset (async, `reset`=0): state IDLE; `rd`=`we`=0, `addr`=`din`=0, `f_data`=`m_data`=0, `f_valid`=`m_valid`=0, `err`=0, `starve_cnt`=0, wait counter 0. Reset asserted mid-BUSY drops the strobe immediately, with no valid pulse.
- Request sampled at edge N (IDLE) → strobe high from edge N+1.
  - With `complete` high at edge N+1+k, valid is high from edge N+2+k for one cycle.
  - Minimum req→valid is 2 cycles (k=0, `complete` in the first BUSY cycle).
- Back-to-back: the earliest next grant is the edge after DONE, so one transaction occupies at least 3 cycles.
- `complete` outside BUSY is ignored.
- Simultaneous `f_req` and `m_req` in IDLE: data wins unless starving.
- Timeout: the strobe is high for exactly `TIMEOUT` cycles. `err` and valid pulse together in DONE.
- Stalls are combinational from `req` and valid. There is no cycle where a requester is both stalled and valid.

## Test plan
- **Reset:** hold `reset`=0 with random inputs → all outputs 0. Assert `reset` mid-BUSY → `rd` drops the same cycle and no `f_valid`.
- **Single fetch:** `f_req`=1, `f_addr`=16'h3000, `complete` after 3 BUSY cycles with `dout`=16'h1234 → `rd`=1 for 3 cycles at `addr`=16'h3000, then `f_valid` for 1 cycle with `f_data`=16'h1234. `f_stall` is high until `f_valid`.
- **Store:** `m_req`=1, `m_we`=1, `m_addr`=16'h4000, `m_wdata`=16'hBEEF, `complete` immediately → `we`=1 for 1 cycle with `din`=16'hBEEF and `rd`=0, then `m_valid` pulses and `m_data` is unchanged.
- **Simultaneous requests:** `f_req` and load `m_req` in the same cycle → data transaction first, then fetch granted the edge after DONE.
- **Starvation:** `f_req` held while `m_req` is re-raised each IDLE, `STARVE_LIMIT`=4 → 4 data transactions, then a fetch, then data resumes with `starve_cnt` cleared.
- **Timeout:** fetch with `complete` held 0, `TIMEOUT`=8 → `rd` high for exactly 8 cycles, then `err`=1 and `f_valid`=1 for one cycle with `f_data`=16'h0000, then IDLE.
